fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 8-bit computer. It owns the program counter, issues one read per instruction to program memory over a req/ack handshake, and presents each fetched byte to the decoder over a valid/ready handshake. It applies the decoder's redirect commands (jump, call, return, halt) and keeps a small return-address stack. It replaces free-running use of the counter as PC with a sequenced fetch loop.

---
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 8-bit computer.
// Owns the PC, fetches one byte per instruction over a req/ack memory
// handshake, hands it to the decoder over valid/ready, and applies the
// decoder's jump/call/ret/halt redirects with a small return-address stack.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    input  logic              instr_ready,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    input  logic [ADDR_W-1:0] tgt_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              stack_err,
    output logic              busy
);

    localparam int unsigned      PTR_W    = $clog2(STACK_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              stack_empty;
    logic              stack_full;
    logic              do_push;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stack_top;
    logic [PTR_W-1:0]  push_idx;
    logic [PTR_W-1:0]  top_idx;

    assign accept      = (state == HOLD) && instr_ready;
    assign stack_empty = (count == '0);
    assign stack_full  = (count == CNT_FULL);
    assign pc_inc      = pc + ADDR_W'(1);
    // Low pointer bits wrap naturally: a full stack (count == DEPTH) maps
    // its top to index DEPTH-1 after the decrement.
    assign push_idx    = count[PTR_W-1:0];
    assign top_idx     = count[PTR_W-1:0] - PTR_W'(1);
    assign stack_top   = stack_mem[top_idx];
    assign do_push     = accept && !ret && call && !stack_full;

    // State register; reset aborts any fetch in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: run leaves IDLE, ack completes a fetch, accept ends a hold.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = FETCH;
            FETCH:   if (mem_ack) state_next = HOLD;
            HOLD:    if (accept) state_next = halt ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        mem_req     = (state == FETCH);
        instr_valid = (state == HOLD);
        busy        = (state != IDLE);
    end

    assign mem_addr = pc;

    // Instruction capture, PC update and stack bookkeeping (ret > call > jump).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_VEC;
            instr     <= '0;
            count     <= '0;
            stack_err <= 1'b0;
        end else begin
            if ((state == FETCH) && mem_ack) begin
                instr <= mem_rdata;
            end
            if (accept) begin
                if (ret) begin
                    if (!stack_empty) begin
                        pc    <= stack_top;
                        count <= count - CNT_W'(1);
                    end else begin
                        stack_err <= 1'b1;
                        pc        <= pc_inc;
                    end
                end else if (call) begin
                    pc <= tgt_addr;
                    if (!stack_full) begin
                        count <= count + CNT_W'(1);
                    end else begin
                        stack_err <= 1'b1;
                    end
                end else if (jump) begin
                    pc <= tgt_addr;
                end else begin
                    pc <= pc_inc;
                end
            end
        end
    end

    // Return-address storage; contents are meaningless above count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_fetch_sequencer;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       jump;
    logic       call;
    logic       ret;
    logic       halt;
    logic [7:0] tgt_addr;
    logic [7:0] pc;
    logic       stack_err;
    logic       busy;

    logic [7:0] mem_img [256];

    int unsigned errors = 0;
    int unsigned checks = 0;

    fetch_sequencer #(
        .ADDR_W(8),
        .DATA_W(8),
        .STACK_DEPTH(4),
        .RESET_VEC(8'h00)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .run(run),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_ready(instr_ready),
        .jump(jump),
        .call(call),
        .ret(ret),
        .halt(halt),
        .tgt_addr(tgt_addr),
        .pc(pc),
        .stack_err(stack_err),
        .busy(busy)
    );

    assign mem_rdata = mem_img[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: active edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 256; i++) mem_img[i] = 8'(i);
    endtask

    task automatic clear_cmds();
        jump = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0; tgt_addr = 8'h00;
    endtask

    task automatic do_reset();
        run = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        clear_cmds();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Fetch one instruction (starting from IDLE or FETCH) and accept it with
    // the given redirect; ok=0 if instr_valid never appeared.
    task automatic fetch_accept(input logic j, input logic c, input logic r,
                                input logic h, input logic [7:0] tgt, output bit ok);
        ok = 1'b0;
        run = 1'b1;
        mem_ack = 1'b1;
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        run = 1'b0;
        if (ok) begin
            jump = j; call = c; ret = r; halt = h; tgt_addr = tgt;
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            clear_cmds();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 8'h00 || instr !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: got pc=%h instr=%h expected pc=00 instr=00", pc, instr);
        end
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got req=%b valid=%b busy=%b err=%b expected all 0",
                     mem_req, instr_valid, busy, stack_err);
        end
    endtask

    task automatic test_sequential();
        fill_identity();
        do_reset();
        run = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL seq_first_req: got req=%b valid=%b addr=%h expected 1 0 00",
                     mem_req, instr_valid, mem_addr);
        end
        tick();
        // Valid in the third cycle counting the one in which run was raised.
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== 8'(n) || pc !== 8'(n)) begin
                errors++;
                $display("FAIL seq_hold: got valid=%b instr=%h pc=%h expected 1 %h %h",
                         instr_valid, instr, pc, 8'(n), 8'(n));
            end
            tick();
            checks++;
            if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'(n + 1)) begin
                errors++;
                $display("FAIL seq_fetch: got valid=%b req=%b addr=%h expected 0 1 %h",
                         instr_valid, mem_req, mem_addr, 8'(n + 1));
            end
            tick();
        end
        run = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || pc !== 8'h09) begin
            errors++;
            $display("FAIL seq_halt: got busy=%b pc=%h expected 0 09", busy, pc);
        end
    endtask

    task automatic test_wait_states();
        fill_identity();
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== 8'(i)) begin
                    errors++;
                    $display("FAIL wait_req: got req=%b addr=%h expected 1 %h", mem_req, mem_addr, 8'(i));
                end
                tick();
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 8'(i) || pc !== 8'(i)) begin
                    errors++;
                    $display("FAIL wait_hold: got valid=%b instr=%h pc=%h expected 1 %h %h",
                             instr_valid, instr, pc, 8'(i), 8'(i));
                end
                tick();
            end
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            checks++;
            if (pc !== 8'(i + 1) || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_accept: got pc=%h valid=%b expected %h 0", pc, instr_valid, 8'(i + 1));
            end
        end
    endtask

    task automatic test_call_return();
        bit ok;
        do_reset();
        fetch_accept(1, 0, 0, 0, 8'h10, ok);
        checks++;
        if (!ok || pc !== 8'h10) begin
            errors++;
            $display("FAIL cr_jump: got ok=%b pc=%h expected 1 10", ok, pc);
        end
        fetch_accept(0, 1, 0, 0, 8'h40, ok);
        checks++;
        if (!ok || pc !== 8'h40) begin
            errors++;
            $display("FAIL cr_call: got ok=%b pc=%h expected 1 40", ok, pc);
        end
        fetch_accept(0, 0, 1, 0, 8'h00, ok);
        checks++;
        if (!ok || pc !== 8'h11 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL cr_ret: got ok=%b pc=%h err=%b expected 1 11 0", ok, pc, stack_err);
        end
    endtask

    task automatic test_stack_limits();
        bit ok;
        logic [7:0] exp_ret [4] = '{8'h41, 8'h31, 8'h21, 8'h01};
        logic [7:0] t;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            t = 8'(8'h20 + i * 8'h10);
            fetch_accept(0, 1, 0, 0, t, ok);
            checks++;
            if (!ok || pc !== t || stack_err !== (i == 4)) begin
                errors++;
                $display("FAIL stk_call%0d: got ok=%b pc=%h err=%b expected 1 %h %b",
                         i, ok, pc, stack_err, t, (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            fetch_accept(0, 0, 1, 0, 8'h00, ok);
            checks++;
            if (!ok || pc !== exp_ret[i] || stack_err !== 1'b1) begin
                errors++;
                $display("FAIL stk_ret%0d: got ok=%b pc=%h err=%b expected 1 %h 1",
                         i, ok, pc, stack_err, exp_ret[i]);
            end
        end
        fetch_accept(0, 0, 1, 0, 8'h00, ok);
        checks++;
        if (!ok || pc !== 8'h02) begin
            errors++;
            $display("FAIL stk_ret_empty: got ok=%b pc=%h expected 1 02", ok, pc);
        end
        do_reset();
        fetch_accept(1, 0, 0, 0, 8'h05, ok);
        fetch_accept(0, 0, 1, 0, 8'h00, ok);
        checks++;
        if (!ok || pc !== 8'h06 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL stk_underflow: got ok=%b pc=%h err=%b expected 1 06 1", ok, pc, stack_err);
        end
    endtask

    task automatic test_priority_wrap();
        bit ok;
        do_reset();
        fetch_accept(1, 1, 1, 0, 8'h80, ok);
        checks++;
        if (!ok || pc !== 8'h01 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL prio_all: got ok=%b pc=%h err=%b expected 1 01 1", ok, pc, stack_err);
        end
        do_reset();
        fetch_accept(1, 0, 0, 0, 8'hFF, ok);
        fetch_accept(0, 0, 0, 0, 8'h00, ok);
        checks++;
        if (!ok || pc !== 8'h00) begin
            errors++;
            $display("FAIL wrap_seq: got ok=%b pc=%h expected 1 00", ok, pc);
        end
        do_reset();
        fetch_accept(1, 0, 0, 0, 8'hFF, ok);
        fetch_accept(0, 1, 0, 0, 8'h30, ok);
        fetch_accept(0, 0, 1, 0, 8'h00, ok);
        checks++;
        if (!ok || pc !== 8'h00 || stack_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_call: got ok=%b pc=%h err=%b expected 1 00 0", ok, pc, stack_err);
        end
    endtask

    task automatic test_halt_reset();
        bit ok;
        fill_identity();
        do_reset();
        fetch_accept(1, 0, 0, 1, 8'h22, ok);
        checks++;
        if (!ok || busy !== 1'b0 || pc !== 8'h22 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle: got ok=%b busy=%b pc=%h req=%b expected 1 0 22 0",
                     ok, busy, pc, mem_req);
        end
        mem_ack = 1'b1;
        tick(); tick(); tick();
        mem_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || pc !== 8'h22) begin
            errors++;
            $display("FAIL halt_stay: got busy=%b pc=%h expected 0 22", busy, pc);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h22) begin
            errors++;
            $display("FAIL halt_resume: got req=%b addr=%h expected 1 22", mem_req, mem_addr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got req=%b pc=%h busy=%b expected 0 00 0", mem_req, pc, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] pc_m;
        logic [7:0] stk [$];
        logic       err_m;
        logic [7:0] exp_i;
        logic       j, c, r, h;
        logic [7:0] t;
        int unsigned guard;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
        do_reset();
        pc_m = 8'h00;
        err_m = 1'b0;
        stk.delete();
        for (int n = 0; n < 80; n++) begin
            run = 1'b1;
            guard = 0;
            while (mem_req !== 1'b1 && guard < 4) begin
                tick();
                guard++;
            end
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== pc_m) begin
                errors++;
                $display("FAIL rand_req: got req=%b addr=%h expected 1 %h", mem_req, mem_addr, pc_m);
            end
            run = 1'($urandom_range(0, 1));
            // Redirects and ready outside HOLD must be ignored.
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                instr_ready = 1'($urandom_range(0, 1));
                jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
                halt = 1'($urandom); tgt_addr = 8'($urandom);
                tick();
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== pc_m || pc !== pc_m) begin
                    errors++;
                    $display("FAIL rand_wait: got req=%b addr=%h pc=%h expected 1 %h %h",
                             mem_req, mem_addr, pc, pc_m, pc_m);
                end
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            exp_i = mem_img[pc_m];
            instr_ready = 1'b0;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== exp_i || pc !== pc_m) begin
                    errors++;
                    $display("FAIL rand_hold: got valid=%b instr=%h pc=%h expected 1 %h %h",
                             instr_valid, instr, pc, exp_i, pc_m);
                end
                mem_ack = 1'($urandom);
                jump = 1'($urandom); call = 1'($urandom); ret = 1'($urandom);
                halt = 1'($urandom); tgt_addr = 8'($urandom);
                tick();
                mem_ack = 1'b0;
            end
            checks++;
            if (instr_valid !== 1'b1 || instr !== exp_i) begin
                errors++;
                $display("FAIL rand_instr: got valid=%b instr=%h expected 1 %h", instr_valid, instr, exp_i);
            end
            r = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 5) == 0);
            h = ($urandom_range(0, 7) == 0);
            t = 8'($urandom);
            jump = j; call = c; ret = r; halt = h; tgt_addr = t;
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
            clear_cmds();
            if (r) begin
                if (stk.size() > 0) pc_m = stk.pop_back();
                else begin err_m = 1'b1; pc_m = pc_m + 8'd1; end
            end else if (c) begin
                if (stk.size() < 4) stk.push_back(pc_m + 8'd1);
                else err_m = 1'b1;
                pc_m = t;
            end else if (j) begin
                pc_m = t;
            end else begin
                pc_m = pc_m + 8'd1;
            end
            checks++;
            if (pc !== pc_m || stack_err !== err_m || busy !== !h || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_accept: got pc=%h err=%b busy=%b valid=%b expected %h %b %b 0",
                         pc, stack_err, busy, instr_valid, pc_m, err_m, !h);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        run = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        jump = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0; tgt_addr = 8'h00;
        fill_identity();
        test_reset();
        test_sequential();
        test_wait_states();
        test_call_return();
        test_stack_limits();
        test_priority_wrap();
        test_halt_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
